// File: rtl/led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// led_pwm_ctrl
//   Memory-mapped LED controller on the CPU I/O bus. Each LED can be driven
//   steady or blinking, and all lit LEDs are modulated by one global PWM duty.
//
// Ports
//   led_clk    system clock
//   ledrst_n   asynchronous active-low reset
//   ledaddrcs  chip select from the I/O decoder
//   ledwrite   write strobe (write accepted on ledaddrcs && ledwrite)
//   ledread    read strobe  (readback driven on ledaddrcs && ledread)
//   ledaddr    register select: 0 DATA, 1 MODE, 2 DUTY, 3 PERIOD
//   ledwdata   write data
//   ledrdata   combinational read data, zero-extended
//   ledout     registered LED drive
// -----------------------------------------------------------------------------
module led_pwm_ctrl #(
  parameter int NUM_LEDS = 16,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50000
) (
  input  logic                led_clk,
  input  logic                ledrst_n,
  input  logic                ledaddrcs,
  input  logic                ledwrite,
  input  logic                ledread,
  input  logic [1:0]          ledaddr,
  input  logic [15:0]         ledwdata,
  output logic [15:0]         ledrdata,
  output logic [NUM_LEDS-1:0] ledout
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_MODE   = 2'd1;
  localparam logic [1:0] A_DUTY   = 2'd2;
  localparam logic [1:0] A_PERIOD = 2'd3;

  logic [NUM_LEDS-1:0] data_q;
  logic [NUM_LEDS-1:0] mode_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [15:0]         period_q;
  logic [PRE_W-1:0]    pre_cnt;
  logic [15:0]         blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic                wr_en;
  logic                tick;
  logic                pwm_on_p0;
  logic [NUM_LEDS-1:0] led_nxt_p0;

  // All-ones duty is forced fully on; otherwise compare against the counter,
  // which would leave a one-cycle gap per PWM period at maximum duty.
  function automatic logic pwm_gate(input logic [PWM_BITS-1:0] cnt,
                                    input logic [PWM_BITS-1:0] duty);
    return (&duty) | (cnt < duty);
  endfunction

  assign wr_en = ledaddrcs && ledwrite;
  // With PRESCALE=1 the counter is pinned at 0 so tick fires every cycle.
  assign tick  = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Register file
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      data_q   <= '0;
      mode_q   <= '0;
      duty_q   <= '1;
      period_q <= '0;
    end else if (wr_en) begin
      case (ledaddr)
        A_DATA:   data_q   <= ledwdata[NUM_LEDS-1:0];
        A_MODE:   mode_q   <= ledwdata[NUM_LEDS-1:0];
        A_DUTY:   duty_q   <= ledwdata[PWM_BITS-1:0];
        default:  period_q <= ledwdata;
      endcase
    end
  end

  // Prescaler and PWM counter
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink half-period counter. A PERIOD write restarts the phase and wins
  // over a coincident tick; PERIOD=0 parks the phase high (steady).
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if ((wr_en && ledaddr == A_PERIOD) || period_q == 16'd0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == period_q - 16'd1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  // Stage p0: combine enables, blink phase and PWM gate
  always_comb begin
    pwm_on_p0  = pwm_gate(pwm_cnt, duty_q);
    led_nxt_p0 = data_q & (~mode_q | {NUM_LEDS{blink_phase}}) & {NUM_LEDS{pwm_on_p0}};
  end

  // Output register: ledout comes straight from flops
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      ledout <= '0;
    end else begin
      ledout <= led_nxt_p0;
    end
  end

  // Readback reflects pre-edge contents, so a same-cycle write returns old data.
  always_comb begin
    ledrdata = '0;
    if (ledaddrcs && ledread) begin
      case (ledaddr)
        A_DATA:   ledrdata[NUM_LEDS-1:0] = data_q;
        A_MODE:   ledrdata[NUM_LEDS-1:0] = mode_q;
        A_DUTY:   ledrdata[PWM_BITS-1:0] = duty_q;
        default:  ledrdata               = period_q;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
module tb_led_pwm_ctrl;

  localparam int PRE = 4;

  logic        led_clk = 1'b0;
  logic        ledrst_n = 1'b1;
  logic        ledaddrcs = 1'b0;
  logic        ledwrite = 1'b0;
  logic        ledread = 1'b0;
  logic [1:0]  ledaddr = 2'd0;
  logic [15:0] ledwdata = 16'd0;
  logic [15:0] ledrdata;
  logic [15:0] ledout;
  logic [15:0] rdata8;
  logic [7:0]  ledout8;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers)
  int m_data, m_mode, m_duty, m_period, m_pre, m_pwm, m_bcnt, m_phase, m_out;

  led_pwm_ctrl #(.NUM_LEDS(16), .PWM_BITS(8), .PRESCALE(PRE)) dut (
    .led_clk(led_clk), .ledrst_n(ledrst_n), .ledaddrcs(ledaddrcs),
    .ledwrite(ledwrite), .ledread(ledread), .ledaddr(ledaddr),
    .ledwdata(ledwdata), .ledrdata(ledrdata), .ledout(ledout)
  );

  led_pwm_ctrl #(.NUM_LEDS(8), .PWM_BITS(8), .PRESCALE(PRE)) dut8 (
    .led_clk(led_clk), .ledrst_n(ledrst_n), .ledaddrcs(ledaddrcs),
    .ledwrite(ledwrite), .ledread(ledread), .ledaddr(ledaddr),
    .ledwdata(ledwdata), .ledrdata(rdata8), .ledout(ledout8)
  );

  always #5 led_clk = ~led_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 0; m_mode = 0; m_duty = 255; m_period = 0;
    m_pre = 0; m_pwm = 0; m_bcnt = 0; m_phase = 1; m_out = 0;
  endtask

  function automatic logic [15:0] model_read();
    if (!(ledaddrcs && ledread)) return 16'd0;
    case (ledaddr)
      2'd0: return 16'(m_data);
      2'd1: return 16'(m_mode);
      2'd2: return 16'(m_duty);
      default: return 16'(m_period);
    endcase
  endfunction

  // One clock edge of the behavioural model, using the bus inputs present at the edge.
  task automatic model_edge();
    bit tick, pwm_on, wr;
    if (!ledrst_n) return;
    wr = ledaddrcs && ledwrite;
    pwm_on = (m_duty == 255) || (m_pwm < m_duty);
    m_out = 0;
    for (int i = 0; i < 16; i++)
      if (m_data[i] && (!m_mode[i] || m_phase != 0) && pwm_on) m_out |= (1 << i);
    tick = (m_pre == PRE - 1);
    m_pre = tick ? 0 : m_pre + 1;
    m_pwm = (m_pwm + 1) % 256;
    if ((wr && ledaddr == 2'd3) || m_period == 0) begin
      m_bcnt = 0; m_phase = 1;
    end else if (tick) begin
      if (m_bcnt == m_period - 1) begin m_bcnt = 0; m_phase = 1 - m_phase; end
      else m_bcnt++;
    end
    if (wr) begin
      case (ledaddr)
        2'd0: m_data = int'(ledwdata);
        2'd1: m_mode = int'(ledwdata);
        2'd2: m_duty = int'(ledwdata[7:0]);
        default: m_period = int'(ledwdata);
      endcase
    end
  endtask

  task automatic step();
    @(posedge led_clk);
    model_edge();
    #1;
    chk("ledout", ledout, 16'(m_out));
    chk("rdata", ledrdata, model_read());
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] v);
    ledaddrcs = 1'b1; ledwrite = 1'b1; ledaddr = a; ledwdata = v;
    step();
    ledaddrcs = 1'b0; ledwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    ledaddrcs = 1'b1; ledread = 1'b1; ledaddr = a;
    #1;
    chk(tag, ledrdata, exp);
    ledaddrcs = 1'b0; ledread = 1'b0;
  endtask

  initial begin
    int hi;
    model_reset();
    // Reset and idle
    #1 ledrst_n = 1'b0;
    repeat (3) step();
    ledrst_n = 1'b1;
    repeat (100) step();
    chk("idle_ledout", ledout, 16'h0000);
    rd_chk("rst_data", 2'd0, 16'h0000);
    rd_chk("rst_mode", 2'd1, 16'h0000);
    rd_chk("rst_duty", 2'd2, 16'h00FF);
    rd_chk("rst_period", 2'd3, 16'h0000);

    // Static write
    wr_reg(2'd0, 16'hA5C3);
    step();
    chk("static_out", ledout, 16'hA5C3);
    rd_chk("static_rb", 2'd0, 16'hA5C3);
    wr_reg(2'd0, 16'hFFFF);
    ledaddrcs = 1'b1; ledread = 1'b1; ledaddr = 2'd0;
    #1;
    chk("rb_16led", ledrdata, 16'hFFFF);
    chk("rb_8led", rdata8, 16'h00FF);
    ledaddrcs = 1'b0; ledread = 1'b0;

    // Blink, PERIOD write aligned with a tick
    wr_reg(2'd1, 16'h0001);
    wr_reg(2'd0, 16'h0003);
    for (int g = 0; g < 8 && m_pre != PRE - 1; g++) step();
    wr_reg(2'd3, 16'd3);
    for (int k = 1; k <= 36; k++) begin
      step();
      chk("blink", {14'd0, ledout[1:0]}, {14'd0, 1'b1, (((k - 1) / 12) % 2) == 0});
    end
    repeat (5) step();
    wr_reg(2'd3, 16'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("period0_steady", {15'd0, ledout[0]}, 16'd1);
    end

    // PWM
    wr_reg(2'd1, 16'h0000);
    wr_reg(2'd0, 16'h0001);
    wr_reg(2'd2, 16'h0040);
    step();
    hi = 0;
    repeat (256) begin step(); hi += int'(ledout[0]); end
    chk("pwm_64of256", 16'(hi), 16'd64);
    wr_reg(2'd2, 16'h0000);
    hi = 0;
    repeat (40) begin step(); hi += int'(ledout[0]); end
    chk("pwm_duty0", 16'(hi), 16'd0);
    wr_reg(2'd2, 16'h00FF);
    step();
    hi = 0;
    repeat (40) begin step(); hi += int'(ledout[0]); end
    chk("pwm_dutyff", 16'(hi), 16'd40);

    // Same-cycle read and write of DATA
    wr_reg(2'd0, 16'h0001);
    ledaddrcs = 1'b1; ledwrite = 1'b1; ledread = 1'b1; ledaddr = 2'd0; ledwdata = 16'h0002;
    #1;
    chk("rw_old", ledrdata, 16'h0001);
    step();
    ledaddrcs = 1'b0; ledwrite = 1'b0; ledread = 1'b0;
    step();
    chk("rw_new_out", ledout, 16'h0002);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        logic [1:0]  a;
        logic [15:0] v;
        a = 2'($urandom_range(0, 3));
        v = 16'($urandom);
        if (a == 2'd3) v = 16'($urandom_range(0, 4));
        if (a == 2'd2 && $urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) != 0) ? 16'h00FF : 16'h0000;
        ledread = 1'($urandom_range(0, 1));
        wr_reg(a, v);
        ledread = 1'b0;
      end else begin
        ledaddrcs = 1'($urandom_range(0, 1));
        ledread = 1'b1;
        ledaddr = 2'($urandom_range(0, 3));
        step();
        ledaddrcs = 1'b0; ledread = 1'b0;
      end
    end

    // Mid-operation reset while blinking with PWM active
    wr_reg(2'd0, 16'h00FF);
    wr_reg(2'd1, 16'h000F);
    wr_reg(2'd2, 16'h0080);
    wr_reg(2'd3, 16'd2);
    repeat (30) step();
    #2 ledrst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_out", ledout, 16'h0000);
    rd_chk("mrst_data", 2'd0, 16'h0000);
    rd_chk("mrst_mode", 2'd1, 16'h0000);
    rd_chk("mrst_duty", 2'd2, 16'h00FF);
    rd_chk("mrst_period", 2'd3, 16'h0000);
    repeat (3) step();
    ledrst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      chk("post_rst_quiet", ledout, 16'h0000);
    end
    wr_reg(2'd0, 16'h0011);
    step();
    chk("post_rst_rewrite", ledout, 16'h0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Memory-mapped LED controller for the MIPS SoC I/O space. It drives NUM_LEDS outputs and supports three features per LED: a static on/off state, an optional blink mode, and a single global PWM brightness control. It sits on the CPU I/O bus behind the address decoder and uses the same chip-select/write strobe scheme as the other SoC peripherals. It adds register readback, which those peripherals do not provide.

Parameters:
NUM_LEDS, 16, number of LED outputs (1..16); register bits at and above NUM_LEDS are ignored on write and read back as 0.
PWM_BITS, 8, width of the PWM counter and duty register (1..16).
PRESCALE, 50000, led_clk cycles per blink tick (1 ms at 50 MHz); must be >= 1.

Ports:
led_clk  input  1  system clock.
ledrst_n  input  1  asynchronous reset, active-low.
ledaddrcs  input  1  chip select from the I/O decoder.
ledwrite  input  1  write strobe; a write is accepted when ledaddrcs && ledwrite at a led_clk rising edge.
ledread  input  1  read strobe.
ledaddr  input  2  register select: 0 DATA, 1 MODE, 2 DUTY, 3 PERIOD.
ledwdata  input  16  write data.
ledrdata  output  16  read data.
ledout  output  NUM_LEDS  registered LED drive.

Behaviour:
- Reset (ledrst_n=0, asynchronous): DATA=0, MODE=0, DUTY=all ones (PWM_BITS), PERIOD=0, prescaler=0, blink counter=0, blink_phase=1, pwm_cnt=0, ledout=0.
- Registers:
  - DATA[NUM_LEDS-1:0]: LED enables.
  - MODE[NUM_LEDS-1:0]: per-LED mode; 1 selects blink, 0 selects steady.
  - DUTY[PWM_BITS-1:0]: PWM duty.
  - PERIOD[15:0]: blink half-period, counted in ticks.
- Writes: a register is updated at the accepting edge. Unused upper bits of ledwdata are discarded.
- Reads: ledrdata is combinational. When ledaddrcs && ledread, ledrdata is the selected register, zero-extended to 16 bits; otherwise ledrdata=0. A simultaneous read and write to the same address returns the old value.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for exactly one cycle when the count equals PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
- Blink counter (16-bit):
  - If PERIOD=0: the counter is held at 0 and blink_phase is held at 1, so blink-mode LEDs behave as steady.
  - Otherwise, on a tick:
    - if counter == PERIOD-1: counter←0 and blink_phase toggles;
    - else: counter increments.
  - Any write to PERIOD clears the counter and sets blink_phase=1 in the same edge. This has priority over a tick in that cycle.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps naturally.
  - pwm_on = 1 if DUTY is all ones; else pwm_on = (pwm_cnt < DUTY).
  - Consequences: DUTY=0 means always off; DUTY=all ones means always on.
- Output, registered:
  - ledout[i] ← DATA[i] & (MODE[i] ? blink_phase : 1) & pwm_on.
  - Latency: a register write at edge N is visible on ledout at edge N+1.
- ledout never glitches: it is driven directly from flops.
- Reset asserted mid-operation forces every flop to its reset value immediately. Operation resumes on the first rising edge after ledrst_n deasserts.

Test Plan:
1. Reset then idle: hold ledrst_n=0, release, run 100 cycles -> ledout=0 and ledrdata=0; then read each register -> DUTY=0x00FF, all other registers 0.
2. Static write: write DATA=0xA5C3 at edge N (DUTY=0xFF, MODE=0) -> ledout=0xA5C3 from edge N+1 onward; readback DATA=0xA5C3. With NUM_LEDS=8, a write of 0xFFFF reads back as 0x00FF.
3. Blink: PRESCALE=4, PERIOD=3, DATA=0x0003, MODE=0x0001 -> ledout[0] toggles every 12 cycles and ledout[1] stays 1; a write of PERIOD=0 mid-phase -> ledout[0]=1 steadily from the next edge.
4. PWM: DUTY=0x40, DATA=0x0001 -> ledout[0] is high for exactly 64 of each 256 cycles; DUTY=0x00 -> constantly 0; DUTY=0xFF -> constantly 1.
5. Boundary write/read: same-cycle read and write of DATA (old value 0x0001, new value 0x0002) -> ledrdata=0x0001 and ledout=0x0002 next cycle; a PERIOD write coinciding with a tick -> counter=0 and blink_phase=1.
6. Mid-operation reset: while blinking with PWM active, pulse ledrst_n low for 3 cycles asynchronously -> ledout=0 immediately, all registers return to reset values, and no ledout activity until registers are rewritten.
